l2_arbiter: RTL and testbench

Two-port arbiter that shares the unified L2 cache between the L1 instruction cache and the L1 data cache. It sits between the two L1 miss/write-back ports and the single L2 CPU-side port (mem_read/mem_write/mem_resp). It latches one request at a time, drives the L2 with registered, stable signals until the L2 responds, and returns the line and a one-cycle response to the winning L1.

---
 rtl/l2_arbiter.sv | 175 +++++++++++++++++
 tb/tb_l2_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter
// Brief    : Shares the unified L2 between the L1 I-cache and the L1 D-cache,
//            one latched transaction at a time, with registered L2 strobes.
// Options  : ARB_ROUND_ROBIN_EN - alternating I/D priority on ties
//            (undefined: the D-cache always wins ties).
// Revision : 1.0 - initial release
// ============================================================================
module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                l2_read_q, l2_read_d;
    logic                l2_write_q, l2_write_d;
    logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
    logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;
    logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_resp_q, i_resp_d;
    logic                d_resp_q, d_resp_d;

    logic                d_valid;
    logic                d_wins_tie;
    logic                pick_d;
    logic                pick_i;

    // Both D strobes high is malformed and counts as no D request.
    assign d_valid = d_read ^ d_write;
    assign pick_d  = d_valid && (!i_read || d_wins_tie);
    assign pick_i  = i_read && !pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_d_q, prio_d_d;   // 1: the D-cache wins the next tie

    always_comb begin
        prio_d_d = prio_d_q;
        if (state_q == IDLE && pick_d) begin
            prio_d_d = 1'b0;
        end else if (state_q == IDLE && pick_i) begin
            prio_d_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_d_q <= 1'b1;
        end else begin
            prio_d_q <= prio_d_d;
        end
    end

    assign d_wins_tie = prio_d_q;
`else
    assign d_wins_tie = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        l2_addr_d  = l2_addr_q;
        l2_wdata_d = l2_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_resp_d   = 1'b0;
        d_resp_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d    = BUSY_D;
                    l2_read_d  = d_read;
                    l2_write_d = d_write;
                    l2_addr_d  = d_addr;
                    l2_wdata_d = d_wdata;
                end else if (pick_i) begin
                    state_d    = BUSY_I;
                    l2_read_d  = 1'b1;
                    l2_write_d = 1'b0;
                    l2_addr_d  = i_addr;
                end
            end
            BUSY_I: begin
                if (l2_resp) begin
                    state_d    = RESP;
                    i_rdata_d  = l2_rdata;
                    i_resp_d   = 1'b1;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                end
            end
            BUSY_D: begin
                if (l2_resp) begin
                    state_d    = RESP;
                    d_rdata_d  = l2_rdata;
                    d_resp_d   = 1'b1;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                end
            end
            // The response pulse is already registered; RESP only forces one
            // idle cycle before the next grant.
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_resp_q   <= 1'b0;
            d_resp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_resp_q   <= i_resp_d;
            d_resp_q   <= d_resp_d;
        end
    end

    assign l2_read  = l2_read_q;
    assign l2_write = l2_write_q;
    assign l2_addr  = l2_addr_q;
    assign l2_wdata = l2_wdata_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign i_resp   = i_resp_q;
    assign d_resp   = d_resp_q;

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_arbiter
// Brief    : Scoreboard bench for l2_arbiter with a transaction-level model of
//            the two L1 requesters, the arbitration rule and the L2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata = '0;
    logic              l2_resp = 1'b0;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } l2_txn_t;

    typedef struct {
        bit                is_d;
        bit                is_rd;
        logic [LINE_W-1:0] data;
    } resp_t;

    l2_txn_t exp_l2_q[$];
    resp_t   exp_resp_q[$];
    bit      dut_grants[$];   // 1: D side was served
    bit      exp_active = 1'b0;
    bit      resp_due = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    // Requester / environment knobs
    int i_rate = 0, d_rate = 0, bogus_rate = 0, spur_rate = 0, force_lat = 0;
    bit d_bogus_force = 1'b0, spur_force = 1'b0, fix_data_en = 1'b0;
    logic [LINE_W-1:0] fix_data = '0;
    bit i_pend = 1'b0, d_pend = 1'b0, d_pwr = 1'b0, rel_i = 1'b0, rel_d = 1'b0;

    // Reference model state
    bit m_busy = 1'b0, m_cool = 1'b0, m_owner_d = 1'b0, m_wr = 1'b0;
    int m_lat = 0;
`ifdef ARB_ROUND_ROBIN_EN
    bit m_ptr_d = 1'b1;
`endif

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input int act, input int exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock of stimulus: requesters, then the model's view of the next edge.
    task automatic step();
        bit dv, iv, tie_d, d_wins, bog;
        @(negedge clk);
        if (rel_i) i_pend = 1'b0;
        if (rel_d) d_pend = 1'b0;
        rel_i = 1'b0;
        rel_d = 1'b0;
        if (!i_pend && $urandom_range(99) < i_rate) begin
            i_pend = 1'b1;
            i_addr = 16'($urandom());
        end
        if (!d_pend && $urandom_range(99) < d_rate) begin
            d_pend  = 1'b1;
            d_pwr   = ($urandom_range(1) == 1);
            d_addr  = 16'($urandom());
            d_wdata = rand_line();
        end
        i_read = i_pend;
        if (d_pend) begin
            d_read  = !d_pwr;
            d_write = d_pwr;
        end else begin
            bog = d_bogus_force || ($urandom_range(99) < bogus_rate);
            d_read  = bog;
            d_write = bog;
        end

        resp_due = 1'b0;
        l2_rdata = rand_line();
        if (m_busy) begin
            m_lat--;
            l2_resp = 1'b0;
            if (m_lat == 0) begin
                l2_resp = 1'b1;
                if (fix_data_en) l2_rdata = fix_data;
                exp_resp_q.push_back('{is_d: m_owner_d, is_rd: !m_wr, data: l2_rdata});
                resp_due   = 1'b1;
                exp_active = 1'b0;
                m_busy     = 1'b0;
                m_cool     = 1'b1;
                if (m_owner_d) rel_d = 1'b1;
                else           rel_i = 1'b1;
            end else begin
                exp_active = 1'b1;
            end
        end else if (m_cool) begin
            m_cool  = 1'b0;
            l2_resp = spur_force || ($urandom_range(99) < spur_rate);
        end else begin
            l2_resp = spur_force || ($urandom_range(99) < spur_rate);
            dv = d_read ^ d_write;
            iv = i_read;
`ifdef ARB_ROUND_ROBIN_EN
            tie_d = m_ptr_d;
`else
            tie_d = 1'b1;
`endif
            if (dv || iv) begin
                d_wins = dv && (!iv || tie_d);
                if (d_wins) exp_l2_q.push_back('{wr: d_write, addr: d_addr, wdata: d_wdata});
                else        exp_l2_q.push_back('{wr: 1'b0, addr: i_addr, wdata: '0});
                m_busy     = 1'b1;
                m_owner_d  = d_wins;
                m_wr       = d_wins && d_write;
                m_lat      = (force_lat > 0) ? force_lat : int'($urandom_range(6, 1));
                exp_active = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                m_ptr_d    = !d_wins;
`endif
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        i_rate = 0; d_rate = 0; bogus_rate = 0; spur_rate = 0;
        while ((i_pend || d_pend || m_busy || m_cool) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) note_fail("drain_timeout", n, 300);
        step();
        step();
    endtask

    // Monitor: compares DUT outputs with the scoreboard, away from the edge.
    l2_txn_t mon_cur;
    bit      mon_prev = 1'b0;
    initial begin
        bit str;
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            str = l2_read | l2_write;
            check("l2_active", str, exp_active);
            if (str && !mon_prev) begin
                if (exp_l2_q.size() == 0) begin
                    note_fail("l2_unexpected", 1, 0);
                end else begin
                    mon_cur = exp_l2_q.pop_front();
                    check("l2_write", l2_write, mon_cur.wr);
                    check("l2_read", l2_read, !mon_cur.wr);
                    check("l2_addr", l2_addr, mon_cur.addr);
                    if (mon_cur.wr) check("l2_wdata", l2_wdata, mon_cur.wdata);
                end
            end else if (str) begin
                check("l2_write_hold", l2_write, mon_cur.wr);
                check("l2_addr_hold", l2_addr, mon_cur.addr);
                if (mon_cur.wr) check("l2_wdata_hold", l2_wdata, mon_cur.wdata);
            end
            mon_prev = str;

            if (i_resp && d_resp) note_fail("both_resp", 1, 0);
            if (i_resp || d_resp) begin
                if (exp_resp_q.size() == 0) begin
                    note_fail("resp_spurious", 1, 0);
                end else begin
                    e = exp_resp_q.pop_front();
                    check("resp_side", d_resp, e.is_d);
                    if (e.is_rd && e.is_d)  check("d_rdata", d_rdata, e.data);
                    if (e.is_rd && !e.is_d) check("i_rdata", i_rdata, e.data);
                    dut_grants.push_back(d_resp);
                end
            end else if (resp_due) begin
                note_fail("resp_missing", 0, 1);
                void'(exp_resp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_i_resp", i_resp, 1'b0);
        check("rst_d_resp", d_resp, 1'b0);
        check("rst_l2_read", l2_read, 1'b0);
        check("rst_l2_write", l2_write, 1'b0);
        check("rst_l2_addr", l2_addr, '0);
        check("rst_l2_wdata", l2_wdata, '0);
        check("rst_i_rdata", i_rdata, '0);
        check("rst_d_rdata", d_rdata, '0);
        reset = 1'b0;
        step();

        // Lone D write
        dut_grants.delete();
        d_pend = 1'b1; d_pwr = 1'b1; d_addr = 16'h4000;
        d_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        force_lat = 4;
        drain();
        check("dw_count", dut_grants.size(), 1);
        if (dut_grants.size() > 0) check("dw_side", dut_grants[0], 1'b1);

        // Lone I read, three-cycle L2 latency, fixed line
        dut_grants.delete();
        i_pend = 1'b1; i_addr = 16'h1230;
        force_lat = 3; fix_data_en = 1'b1; fix_data = {16{8'hA5}};
        drain();
        fix_data_en = 1'b0;
        check("ir_count", dut_grants.size(), 1);
        if (dut_grants.size() > 0) check("ir_side", dut_grants[0], 1'b0);
        check("ir_rdata_held", i_rdata, {16{8'hA5}});

        // Simultaneous I and D reads
        dut_grants.delete();
        force_lat = 2;
        i_pend = 1'b1; i_addr = 16'h0100;
        d_pend = 1'b1; d_pwr = 1'b0; d_addr = 16'h0200; d_wdata = rand_line();
        drain();
        check("tie_count", dut_grants.size(), 2);
        if (dut_grants.size() > 1) begin
            check("tie_first", dut_grants[0], 1'b1);
            check("tie_second", dut_grants[1], 1'b0);
        end

        // Continuous requests from both sides
        dut_grants.delete();
        force_lat = 0;
        i_rate = 100; d_rate = 100;
        for (int n = 0; n < 400 && dut_grants.size() < 6; n++) step();
        drain();
        if (dut_grants.size() < 6) note_fail("fair_count", dut_grants.size(), 6);
        for (int k = 0; k < 6 && k < dut_grants.size(); k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            check($sformatf("fair_grant%0d", k), dut_grants[k], (k % 2) == 0);
`else
            check($sformatf("fair_grant%0d", k), dut_grants[k], 1'b1);
`endif
        end

        // Malformed D request (read and write together) is ignored
        dut_grants.delete();
        d_bogus_force = 1'b1;
        repeat (5) step();
        d_bogus_force = 1'b0;
        check("bogus_no_grant", dut_grants.size(), 0);
        d_pend = 1'b1; d_pwr = 1'b0; d_addr = 16'h5555;
        drain();
        check("bogus_then_read", dut_grants.size(), 1);

        // Reset in the middle of a D transaction
        force_lat = 20;
        d_pend = 1'b1; d_pwr = 1'b0; d_addr = 16'h2222; d_wdata = rand_line();
        repeat (3) step();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_l2_read", l2_read, 1'b0);
        check("abort_l2_write", l2_write, 1'b0);
        check("abort_l2_addr", l2_addr, '0);
        check("abort_d_resp", d_resp, 1'b0);
        m_busy = 1'b0; m_cool = 1'b0; exp_active = 1'b0; resp_due = 1'b0;
        rel_i = 1'b0; rel_d = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
        exp_l2_q.delete();
        exp_resp_q.delete();
`ifdef ARB_ROUND_ROBIN_EN
        m_ptr_d = 1'b1;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dut_grants.delete();
        force_lat = 0;
        spur_force = 1'b1;
        step();
        step();
        spur_force = 1'b0;
        check("abort_no_resp", dut_grants.size(), 0);
        d_pend = 1'b1; d_pwr = 1'b0; d_addr = 16'h3333;
        drain();
        check("after_abort_served", dut_grants.size(), 1);

        // Randomized traffic
        i_rate = 25; d_rate = 25; bogus_rate = 15; spur_rate = 20;
        repeat (3000) step();
        drain();
        check("left_l2", exp_l2_q.size(), 0);
        check("left_resp", exp_resp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
